bit_serializer: RTL



---
 rtl/bit_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: a small word FIFO feeding a registered one-bit serial line.
// Queued words stream back-to-back; the line idles at 0 when nothing is queued.
module bit_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    input  logic             io_in_msbFirst,
    input  logic             io_en,
    output logic             io_out,
    output logic             io_out_valid,
    output logic             io_out_last,
    output logic             io_busy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // FIFO storage: {msbFirst, bits}
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             msb_q, msb_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             push, pop, load;
    logic [WIDTH-1:0] head_bits;
    logic             head_msb;

    assign io_in_ready  = (count_q < CW'(DEPTH));
    assign io_busy      = (count_q != '0) || (state_q == StShift);
    assign io_out       = out_q;
    assign io_out_valid = valid_q;
    assign io_out_last  = last_q;

    assign push      = io_in_valid && io_in_ready;
    assign head_bits = mem_q[rd_ptr_q][WIDTH-1:0];
    assign head_msb  = mem_q[rd_ptr_q][WIDTH];
    assign pop       = load;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        msb_d   = msb_q;
        out_d   = out_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        load    = 1'b0;
        if (io_en) begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) load = 1'b1;
                    else               out_d = 1'b0;
                end
                StShift: begin
                    if (rem_q != '0) begin
                        valid_d = 1'b1;
                        last_d  = (rem_q == RW'(1));
                        rem_d   = rem_q - RW'(1);
                        if (msb_q) begin
                            out_d  = sreg_q[WIDTH-1];
                            sreg_d = sreg_q << 1;
                        end else begin
                            out_d  = sreg_q[0];
                            sreg_d = sreg_q >> 1;
                        end
                    end else if (count_q != '0) begin
                        // Last bit is on the line; chain straight into the next word.
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        out_d   = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (load) begin
                state_d = StShift;
                msb_d   = head_msb;
                rem_d   = RW'(WIDTH - 1);
                valid_d = 1'b1;
                if (head_msb) begin
                    out_d  = head_bits[WIDTH-1];
                    sreg_d = head_bits << 1;
                end else begin
                    out_d  = head_bits[0];
                    sreg_d = head_bits >> 1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            sreg_q   <= '0;
            rem_q    <= '0;
            msb_q    <= 1'b0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            msb_q   <= msb_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {io_in_msbFirst, io_in_bits};
    end

endmodule
